// File: rtl/rip_mem_arbiter.sv
// rip_mem_arbiter: shares one sync-read, byte-write memory between IF and MA. MA has priority; a starvation counter forces an IF win.
// Grant is combinational, response arrives 1 cycle later with no backpressure. Define RIP_ARB_PERF_EN to add conflict/force counters.
module rip_mem_arbiter #(
  parameter int NUM_COL      = 4,
  parameter int COL_WIDTH    = 8,
  parameter int DATA_WIDTH   = NUM_COL*COL_WIDTH,
  parameter int ADDR_WIDTH   = 20,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ma_req,
  input  logic [NUM_COL-1:0]    ma_we,
  input  logic [DATA_WIDTH-1:0] ma_addr,
  input  logic [DATA_WIDTH-1:0] ma_wdata,
  output logic                  ma_gnt,
  output logic                  ma_rvalid,
  output logic [DATA_WIDTH-1:0] ma_rdata,
  output logic                  mem_en,
  output logic [NUM_COL-1:0]    mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef RIP_ARB_PERF_EN
  ,
  output logic [31:0]           perf_conflict_cnt,
  output logic [31:0]           perf_force_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MA   = 2'd2
  } owner_e;

  owner_e                resp_owner, resp_owner_nxt;
  logic [3:0]            starve_cnt;
  logic                  force_if;
  logic [DATA_WIDTH-1:0] if_rdata_q, ma_rdata_q;
  logic [ADDR_WIDTH-1:0] if_word, ma_word;

  // Byte offset and bits beyond the memory size are dropped, so addresses wrap.
  assign if_word = if_addr[ADDR_WIDTH+1:2];
  assign ma_word = ma_addr[ADDR_WIDTH+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[DATA_WIDTH-1:ADDR_WIDTH+2], if_addr[1:0],
                              ma_addr[DATA_WIDTH-1:ADDR_WIDTH+2], ma_addr[1:0]};

  assign force_if = (starve_cnt == LIMIT);
  assign if_gnt   = if_req & (~ma_req | force_if);
  assign ma_gnt   = ma_req & ~if_gnt;

  assign mem_en    = if_gnt | ma_gnt;
  assign mem_addr  = if_gnt ? if_word : ma_word;
  assign mem_we    = ma_we & {NUM_COL{ma_gnt}};
  assign mem_wdata = ma_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_owner <= OWN_NONE;
    end else begin
      resp_owner <= resp_owner_nxt;
    end
  end

  always_comb begin
    resp_owner_nxt = OWN_NONE;
    if (if_gnt) begin
      resp_owner_nxt = OWN_IF;
    end else if (ma_gnt) begin
      resp_owner_nxt = OWN_MA;
    end
  end

  assign if_rvalid = (resp_owner == OWN_IF);
  assign ma_rvalid = (resp_owner == OWN_MA);

  // Owner sees memory data directly; the other side keeps its last response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      ma_rdata_q <= '0;
    end else begin
      if (resp_owner == OWN_IF) if_rdata_q <= mem_rdata;
      if (resp_owner == OWN_MA) ma_rdata_q <= mem_rdata;
    end
  end

  assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
  assign ma_rdata = ma_rvalid ? mem_rdata : ma_rdata_q;

`ifdef RIP_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_cnt <= 32'd0;
      perf_force_cnt    <= 32'd0;
    end else begin
      if (if_req && ma_req) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (force_if && if_req && ma_req) perf_force_cnt <= perf_force_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rip_mem_arbiter.sv
// Directed bench for rip_mem_arbiter with a behavioural sync-read, byte-write memory model.
module tb_rip_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ma_req;
  logic [3:0]  ma_we;
  logic [31:0] ma_addr, ma_wdata;
  logic        ma_gnt, ma_rvalid;
  logic [31:0] ma_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef RIP_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt, perf_force_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic        init_mem;
  logic [31:0] mem [256];
  logic [31:0] mem_q;

  always #5 clk = ~clk;

  rip_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef RIP_ARB_PERF_EN
    , .perf_conflict_cnt(perf_conflict_cnt), .perf_force_cnt(perf_force_cnt)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    if (i == 5) return 32'hDEADBEEF;
    if (i == 8) return 32'h11223344;
    return {b, b, b, b};
  endfunction

  // Read-first memory: a store returns the word as it was before the write.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_q <= 32'd0;
    end else if (mem_en) begin
      mem_q <= mem[mem_addr[7:0]];
      for (int c = 0; c < 4; c++)
        if (mem_we[c]) mem[mem_addr[7:0]][c*8 +: 8] <= mem_wdata[c*8 +: 8];
    end
  end
  assign mem_rdata = mem_q;

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'd0;
    ma_req = 1'b0; ma_we = 4'd0; ma_addr = 32'd0; ma_wdata = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_mem = 1'b1; idle_inputs();
    next_cycle(); next_cycle();
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL reset_if_rvalid got %b want 0", if_rvalid); end
    checks++; if (ma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ma_rvalid got %b want 0", ma_rvalid); end
    checks++; if (if_rdata !== 32'd0) begin errors++; $display("FAIL reset_if_rdata got %h want 0", if_rdata); end
    checks++; if (ma_rdata !== 32'd0) begin errors++; $display("FAIL reset_ma_rdata got %h want 0", ma_rdata); end
    checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL reset_starve got %0d want 0", dut.starve_cnt); end
    init_mem = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h14;
    @(negedge clk);
    checks++; if ({if_gnt, ma_gnt, mem_en} !== 3'b101) begin errors++; $display("FAIL ifrd_gnt got %b want 101", {if_gnt, ma_gnt, mem_en}); end
    checks++; if (mem_addr !== 20'd5) begin errors++; $display("FAIL ifrd_addr got %h want 5", mem_addr); end
    checks++; if (mem_we !== 4'd0) begin errors++; $display("FAIL ifrd_we got %b want 0000", mem_we); end
    next_cycle(); if_req = 1'b0;
    checks++; if ({if_rvalid, ma_rvalid} !== 2'b10) begin errors++; $display("FAIL ifrd_rvalid got %b want 10", {if_rvalid, ma_rvalid}); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ifrd_data got %h want deadbeef", if_rdata); end
    next_cycle();
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL ifrd_pulse got %b want 0", if_rvalid); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ifrd_hold got %h want deadbeef", if_rdata); end
  endtask

  task automatic test_ma_store();
    ma_req = 1'b1; ma_we = 4'b0100; ma_addr = 32'h22; ma_wdata = 32'h00AB0000;
    @(negedge clk);
    checks++; if ({if_gnt, ma_gnt} !== 2'b01) begin errors++; $display("FAIL st_gnt got %b want 01", {if_gnt, ma_gnt}); end
    checks++; if (mem_we !== 4'b0100) begin errors++; $display("FAIL st_we got %b want 0100", mem_we); end
    checks++; if (mem_addr !== 20'd8) begin errors++; $display("FAIL st_addr got %h want 8", mem_addr); end
    checks++; if (mem_wdata !== 32'h00AB0000) begin errors++; $display("FAIL st_wdata got %h want 00ab0000", mem_wdata); end
    next_cycle(); idle_inputs();
    checks++; if ({if_rvalid, ma_rvalid} !== 2'b01) begin errors++; $display("FAIL st_rvalid got %b want 01", {if_rvalid, ma_rvalid}); end
    checks++; if (ma_rdata !== 32'h11223344) begin errors++; $display("FAIL st_preword got %h want 11223344", ma_rdata); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_if_hold got %h want deadbeef", if_rdata); end
    if_req = 1'b1; if_addr = 32'h20;
    next_cycle(); if_req = 1'b0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h11AB3344) begin errors++; $display("FAIL st_readback got %b/%h want 1/11ab3344", if_rvalid, if_rdata); end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp_if;
    if_req = 1'b1; if_addr = 32'h04;
    ma_req = 1'b1; ma_we = 4'd0; ma_addr = 32'h0C;
    for (int c = 1; c <= 10; c++) begin
      exp_if = (c == 5) || (c == 10);
      @(negedge clk);
      checks++; if ({if_gnt, ma_gnt} !== {exp_if, ~exp_if}) begin errors++; $display("FAIL starve_gnt cyc %0d got %b want %b", c, {if_gnt, ma_gnt}, {exp_if, ~exp_if}); end
      next_cycle();
      if (exp_if) begin
        checks++; if ({if_rvalid, ma_rvalid} !== 2'b10 || if_rdata !== 32'h01010101) begin errors++; $display("FAIL starve_resp cyc %0d got %b/%h want 10/01010101", c, {if_rvalid, ma_rvalid}, if_rdata); end
      end else begin
        checks++; if ({if_rvalid, ma_rvalid} !== 2'b01 || ma_rdata !== 32'h03030303) begin errors++; $display("FAIL starve_resp cyc %0d got %b/%h want 01/03030303", c, {if_rvalid, ma_rvalid}, ma_rdata); end
      end
    end
    idle_inputs();
`ifdef RIP_ARB_PERF_EN
    checks++; if (perf_conflict_cnt !== 32'd10) begin errors++; $display("FAIL perf_conflict got %0d want 10", perf_conflict_cnt); end
    checks++; if (perf_force_cnt !== 32'd2) begin errors++; $display("FAIL perf_force got %0d want 2", perf_force_cnt); end
`endif
    next_cycle();
  endtask

  task automatic test_back_to_back();
    if_req = 1'b1; if_addr = 32'h04;
    @(negedge clk);
    checks++; if ({if_gnt, ma_gnt} !== 2'b10) begin errors++; $display("FAIL b2b_g1 got %b want 10", {if_gnt, ma_gnt}); end
    next_cycle();
    if_req = 1'b0; ma_req = 1'b1; ma_we = 4'd0; ma_addr = 32'h0C;
    checks++; if ({if_rvalid, ma_rvalid} !== 2'b10 || if_rdata !== 32'h01010101) begin errors++; $display("FAIL b2b_r1 got %b/%h want 10/01010101", {if_rvalid, ma_rvalid}, if_rdata); end
    @(negedge clk);
    checks++; if ({if_gnt, ma_gnt} !== 2'b01) begin errors++; $display("FAIL b2b_g2 got %b want 01", {if_gnt, ma_gnt}); end
    next_cycle();
    ma_req = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    checks++; if ({if_rvalid, ma_rvalid} !== 2'b01 || ma_rdata !== 32'h03030303) begin errors++; $display("FAIL b2b_r2 got %b/%h want 01/03030303", {if_rvalid, ma_rvalid}, ma_rdata); end
    @(negedge clk);
    checks++; if ({if_gnt, ma_gnt} !== 2'b10) begin errors++; $display("FAIL b2b_g3 got %b want 10", {if_gnt, ma_gnt}); end
    next_cycle(); idle_inputs();
    checks++; if ({if_rvalid, ma_rvalid} !== 2'b10 || if_rdata !== 32'h04040404) begin errors++; $display("FAIL b2b_r3 got %b/%h want 10/04040404", {if_rvalid, ma_rvalid}, if_rdata); end
    checks++; if (ma_rdata !== 32'h03030303) begin errors++; $display("FAIL b2b_ma_hold got %h want 03030303", ma_rdata); end
    next_cycle();
  endtask

  task automatic test_drop_at_limit();
    if_req = 1'b1; if_addr = 32'h04;
    ma_req = 1'b1; ma_we = 4'd0; ma_addr = 32'h0C;
    for (int c = 0; c < 4; c++) next_cycle();
    checks++; if (dut.starve_cnt !== 4'd4) begin errors++; $display("FAIL drop_cnt_at_limit got %0d want 4", dut.starve_cnt); end
    if_req = 1'b0;
    @(negedge clk);
    checks++; if ({if_gnt, ma_gnt} !== 2'b01) begin errors++; $display("FAIL drop_no_phantom got %b want 01", {if_gnt, ma_gnt}); end
    next_cycle();
    checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL drop_cnt_clear got %0d want 0", dut.starve_cnt); end
    if_req = 1'b1;
    @(negedge clk);
    checks++; if ({if_gnt, ma_gnt} !== 2'b01) begin errors++; $display("FAIL drop_restart got %b want 01", {if_gnt, ma_gnt}); end
    next_cycle(); idle_inputs();
    next_cycle();
  endtask

  task automatic test_addr_wrap();
    if_req = 1'b1; if_addr = 32'hFFC00017;
    @(negedge clk);
    checks++; if (mem_addr !== 20'd5) begin errors++; $display("FAIL wrap_if_addr got %h want 00005", mem_addr); end
    next_cycle(); if_req = 1'b0;
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_if_data got %h want deadbeef", if_rdata); end
    ma_req = 1'b1; ma_we = 4'd0; ma_addr = 32'hFFFFFFFF;
    @(negedge clk);
    checks++; if (mem_addr !== 20'hFFFFF || mem_we !== 4'd0) begin errors++; $display("FAIL wrap_ma_addr got %h/%b want fffff/0000", mem_addr, mem_we); end
    next_cycle(); idle_inputs();
    checks++; if (ma_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_ma_data got %h want ffffffff", ma_rdata); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h04;
    ma_req = 1'b1; ma_we = 4'd0; ma_addr = 32'h0C;
    @(negedge clk);
    checks++; if ({if_gnt, ma_gnt} !== 2'b01) begin errors++; $display("FAIL rmid_gnt got %b want 01", {if_gnt, ma_gnt}); end
    next_cycle();
    rst_n = 1'b0; idle_inputs();
    #1;
    checks++; if (ma_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid got %b want 0", ma_rvalid); end
    checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL rmid_starve got %0d want 0", dut.starve_cnt); end
    checks++; if (ma_rdata !== 32'd0) begin errors++; $display("FAIL rmid_rdata got %h want 0", ma_rdata); end
    @(negedge clk); rst_n = 1'b1;
    next_cycle();
    checks++; if ({if_rvalid, ma_rvalid} !== 2'b00) begin errors++; $display("FAIL rmid_no_replay got %b want 00", {if_rvalid, ma_rvalid}); end
    if_req = 1'b1; if_addr = 32'h14;
    @(negedge clk);
    checks++; if ({if_gnt, ma_gnt, mem_addr} !== {2'b10, 20'd5}) begin errors++; $display("FAIL rmid_first_gnt got %b/%h want 10/5", {if_gnt, ma_gnt}, mem_addr); end
    next_cycle(); if_req = 1'b0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rmid_first_resp got %b/%h want 1/deadbeef", if_rvalid, if_rdata); end
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_if_read();
    test_ma_store();
    test_starvation();
    test_back_to_back();
    test_drop_at_limit();
    test_addr_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rip_mem_arbiter.md
Name: rip_mem_arbiter

Overview:
- Shares one single-port, byte-write-enabled, synchronous-read memory block between two requesters: instruction fetch (IF) and memory access (MA).
- Sits between the pipeline stages and the memory array.
- Grants at most one request per cycle and routes the 1-cycle-latency read data back to the winner.
- MA has priority; a starvation counter guarantees IF forward progress.

Parameters:
- NUM_COL, 4, byte columns per word.
- COL_WIDTH, 8, bits per column.
- DATA_WIDTH, NUM_COL*COL_WIDTH, word width.
- ADDR_WIDTH, 20, word-address width of the memory.
- STARVE_LIMIT, 4, consecutive IF denials before IF is forced to win (1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF read request.
- if_addr  in  DATA_WIDTH  IF byte address; word index = if_addr[ADDR_WIDTH+1:2].
- if_gnt  out  1  IF request accepted this cycle (combinational).
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  DATA_WIDTH  IF read data.
- ma_req  in  1  MA request.
- ma_we  in  NUM_COL  MA per-column write enables; all-zero means read.
- ma_addr  in  DATA_WIDTH  MA byte address; word index = ma_addr[ADDR_WIDTH+1:2].
- ma_wdata  in  DATA_WIDTH  MA write data, already lane-aligned.
- ma_gnt  out  1  MA request accepted this cycle (combinational).
- ma_rvalid  out  1  MA response valid; issued for reads and writes.
- ma_rdata  out  DATA_WIDTH  MA read data (pre-write word for stores).
- mem_en  out  1  memory enable.
- mem_we  out  NUM_COL  memory column write enables.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_en.

Behaviour:
- Reset (async assert, sync release): if_rvalid=0, ma_rvalid=0, rdata outputs=0, starve_cnt=0, resp_owner=NONE.
- Grant, combinational per cycle:
  - force_if = (starve_cnt == STARVE_LIMIT).
  - if_gnt = if_req & (~ma_req | force_if).
  - ma_gnt = ma_req & ~if_gnt.
  - Never both grants high.
- Memory drive:
  - mem_en = if_gnt | ma_gnt.
  - mem_addr = word index of the granted requester.
  - mem_we = ma_we & {NUM_COL{ma_gnt}}; zero on an IF grant or no grant.
  - mem_wdata = ma_wdata.
  - mem_addr and mem_wdata are don't-care when mem_en=0, but driven deterministically from the MA inputs.
- Response FSM (resp_owner register): states NONE, IF, MA.
  - Next state = IF on if_gnt, MA on ma_gnt, else NONE.
  - if_rvalid = (resp_owner==IF); ma_rvalid = (resp_owner==MA).
  - rdata of the owner = mem_rdata. Non-owner rdata holds its last value.
  - Latency: grant in cycle N -> rvalid in cycle N+1. Back-to-back grants give one response per cycle.
- Requesters must not backpressure responses; rvalid is a single-cycle pulse.
- A requester holds req, addr, we and wdata stable until it sees gnt. After gnt it may change them in the next cycle.
- Starvation counter (starve_cnt, 4 bits):
  - Increments when if_req & ~if_gnt, saturating at STARVE_LIMIT.
  - Clears when if_gnt, or when if_req=0.
- Boundary cases:
  - Simultaneous requests: MA wins unless force_if. When forced, IF wins and MA is denied for exactly that cycle.
  - STARVE_LIMIT reached while if_req drops: the counter clears and there is no phantom grant.
  - Reset mid-transaction: the pending rvalid is dropped, not replayed. Requesters re-issue after reset.
  - Address bits above ADDR_WIDTH+1 and below bit 2 are ignored (wrap-around by truncation).

Optional Feature:
- Macro: RIP_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_conflict_cnt (32) and perf_force_cnt (32), both reset to 0.
  - perf_conflict_cnt increments each cycle with if_req & ma_req.
  - perf_force_cnt increments each cycle force_if & if_req & ma_req.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- IF-only read, memory preloaded with word 5 = 0xDEADBEEF: if_req=1, if_addr=0x14 -> if_gnt same cycle, mem_addr=5, mem_we=0, next cycle if_rvalid=1 and if_rdata=0xDEADBEEF.
- MA byte store: ma_we=4'b0100, ma_addr=0x22, ma_wdata=0x00AB0000 -> ma_gnt, mem_we=4'b0100, mem_addr=8, ma_rvalid next cycle. A later IF read of 0x20 returns byte 2 = 0xAB with the other bytes unchanged.
- Conflict with STARVE_LIMIT=4, if_req and ma_req held high: ma_gnt for 4 cycles, if_gnt on cycle 5, then ma_gnt resumes. Responses alternate owners correctly with no gap.
- Back-to-back alternating grants IF, MA, IF -> rvalid pulses on the matching side in cycles N+1..N+3, each with the correct data and no cross-routing.
- Assert rst_n=0 the cycle after an ma_gnt -> ma_rvalid stays 0, starve_cnt=0; after release, the first request behaves as from reset.
- With RIP_ARB_PERF_EN, 10 conflict cycles at STARVE_LIMIT=4 -> perf_conflict_cnt=10, perf_force_cnt=2.
